// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator (binary, Gray, bounce, rotate).
// Optional freeze input enabled by defining LED_PATTERN_GEN_PAUSE_EN.
module led_pattern_gen #(
    parameter int LED_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      NOTRESET,
    input  logic [1:0]                mode,
    input  logic [PRESCALE_WIDTH-1:0] rate,
`ifdef LED_PATTERN_GEN_PAUSE_EN
    input  logic                      pause,
`endif
    output logic [LED_WIDTH-1:0]      LED,
    output logic                      step
);
    localparam int PW = $clog2(LED_WIDTH);
    localparam logic [PW-1:0] TOP = PW'(LED_WIDTH - 1);
    logic [PRESCALE_WIDTH-1:0] pre, pre_n;
    logic [LED_WIDTH-1:0]      cnt, cnt_n, ring, ring_n, led_n;
    logic [PW-1:0]             pos, pos_n;
    logic                      dir, dir_n, hold, chg, adv;
    logic [1:0]                mode_q;
    always_comb begin
`ifdef LED_PATTERN_GEN_PAUSE_EN
        hold = pause;
`else
        hold = 1'b0;
`endif
        chg    = mode != mode_q;
        adv    = !chg && !hold && pre >= rate;
        pre_n  = (chg || adv) ? '0 : hold ? pre : pre + 1'b1;
        cnt_n  = chg ? '0 : (adv && !mode_q[1]) ? cnt + 1'b1 : cnt;
        ring_n = chg ? LED_WIDTH'(1) : (adv && mode_q == 2'd3) ? {ring[LED_WIDTH-2:0], ring[LED_WIDTH-1]} : ring;
        pos_n  = pos;
        dir_n  = dir;
        if (chg) begin
            pos_n = '0;
            dir_n = 1'b0;
        end else if (adv && mode_q == 2'd2) begin
            if (!dir && pos == TOP) begin
                dir_n = 1'b1;
                pos_n = pos - 1'b1;
            end else if (dir && pos == '0) begin
                dir_n = 1'b0;
                pos_n = PW'(1);
            end else begin
                pos_n = dir ? pos - 1'b1 : pos + 1'b1;
            end
        end
        // the incoming mode becomes mode_q this edge, so it selects the displayed pattern
        led_n = mode == 2'd0 ? cnt_n :
                mode == 2'd1 ? cnt_n ^ (cnt_n >> 1) :
                mode == 2'd2 ? LED_WIDTH'(1) << pos_n : ring_n;
    end
    always_ff @(posedge clk) begin
        if (NOTRESET) begin
            pre    <= '0;
            cnt    <= '0;
            ring   <= LED_WIDTH'(1);
            pos    <= '0;
            dir    <= 1'b0;
            mode_q <= 2'd0;
            LED    <= '0;
            step   <= 1'b0;
        end else begin
            pre    <= pre_n;
            cnt    <= cnt_n;
            ring   <= ring_n;
            pos    <= pos_n;
            dir    <= dir_n;
            mode_q <= mode;
            LED    <= led_n;
            step   <= adv;
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed and random checks against a closed-form model
// (pattern computed from the number of steps since the last reload).
module tb_led_pattern_gen;
    localparam int W = 8;
    localparam int P = 24;
    logic clk = 1'b0;
    logic NOTRESET = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [P-1:0] rate = '0;
    logic [W-1:0] LED;
    logic step;
`ifdef LED_PATTERN_GEN_PAUSE_EN
    logic pause = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    int pre_m = 0;
    int k_m = 0;
    logic [1:0] mode_m = 2'd0;
    logic step_m = 1'b0;
    logic [W-1:0] gray_seq [5];
    led_pattern_gen #(.LED_WIDTH(W), .PRESCALE_WIDTH(P)) dut (
        .clk(clk),
        .NOTRESET(NOTRESET),
        .mode(mode),
        .rate(rate),
`ifdef LED_PATTERN_GEN_PAUSE_EN
        .pause(pause),
`endif
        .LED(LED),
        .step(step)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [W-1:0] exp_led();
        int c, p;
        c = k_m % (1 << W);
        p = k_m % (2 * W - 2);
        p = p < W ? p : 2 * W - 2 - p;
        if (mode_m == 2'd0) return W'(c);
        if (mode_m == 2'd1) return W'(c ^ (c >> 1));
        if (mode_m == 2'd2) return W'(1 << p);
        return W'(1 << (k_m % W));
    endfunction
    task automatic tick();
        logic hold;
        @(posedge clk);
        hold = 1'b0;
`ifdef LED_PATTERN_GEN_PAUSE_EN
        hold = pause;
`endif
        if (NOTRESET) begin
            pre_m = 0; k_m = 0; mode_m = 2'd0; step_m = 1'b0;
        end else if (mode != mode_m) begin
            pre_m = 0; k_m = 0; mode_m = mode; step_m = 1'b0;
        end else if (hold) begin
            step_m = 1'b0;
        end else if (pre_m >= int'(rate)) begin
            pre_m = 0; k_m++; step_m = 1'b1;
        end else begin
            pre_m++; step_m = 1'b0;
        end
        #1;
        check("led", 32'(LED), 32'(exp_led()));
        check("step", 32'(step), 32'(step_m));
    endtask
    initial begin
        gray_seq = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
        repeat (2) tick();
        check("rst_led", 32'(LED), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        NOTRESET = 1'b0;
        repeat (255) tick();
        check("bin_ff", 32'(LED), 32'hff);
        tick();
        check("bin_wrap", 32'(LED), 32'h0);
        check("bin_step", 32'(step), 32'h1);
        mode = 2'd1; rate = 3;
        tick();
        check("gray_init", 32'(LED), 32'h0);
        for (int i = 0; i < 5; i++) begin
            repeat (3) tick();
            check("gray_nostep", 32'(step), 32'h0);
            tick();
            check("gray_seq", 32'(LED), 32'(gray_seq[i]));
        end
        mode = 2'd2; rate = 0;
        repeat (20) tick();
        mode = 2'd3; rate = 1;
        repeat (19) tick();
        mode = 2'd2;
        tick();
        check("sw_led", 32'(LED), 32'h1);
        check("sw_step", 32'(step), 32'h0);
        tick();
        tick();
        check("sw_first_led", 32'(LED), 32'h2);
        check("sw_first_step", 32'(step), 32'h1);
        mode = 2'd0; rate = 1000;
        repeat (501) tick();
        rate = 10;
        tick();
        check("rate_drop", 32'(step), 32'h1);
        rate = 2;
        repeat (2) tick();
        NOTRESET = 1'b1;
        tick();
        check("rst_mid_led", 32'(LED), 32'h0);
        check("rst_mid_step", 32'(step), 32'h0);
        mode = 2'd3;
        tick();
        NOTRESET = 1'b0;
        tick();
        check("ex_edge1", 32'(LED), 32'h1);
        repeat (2) tick();
        tick();
        check("ex_edge4_led", 32'(LED), 32'h2);
        check("ex_edge4_step", 32'(step), 32'h1);
`ifdef LED_PATTERN_GEN_PAUSE_EN
        mode = 2'd0; rate = 0;
        repeat (5) tick();
        pause = 1'b1;
        repeat (5) tick();
        check("pause_led", 32'(LED), 32'h4);
        pause = 1'b0;
        tick();
        check("pause_resume", 32'(LED), 32'h5);
`endif
        for (int i = 0; i < 4000; i++) begin
            NOTRESET = ($urandom % 150) == 0;
            if (($urandom % 40) == 0) mode = 2'($urandom);
            if (($urandom % 25) == 0) rate = P'($urandom % 6);
`ifdef LED_PATTERN_GEN_PAUSE_EN
            pause = ($urandom % 8) == 0;
`endif
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator and successor to the free-running LED counter. A programmable prescaler divides `clk` into step events. Each step advances one of four selectable display patterns on an `LED_WIDTH`-bit bus. It sits between the board clock/reset and the LED pins and gives a visible, rate-adjustable liveness indicator.

## Interface
- `LED_WIDTH`, default 8: number of LED outputs; legal range 2..32.
- `PRESCALE_WIDTH`, default 24: width of the prescaler counter and of `rate`.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `NOTRESET`  in  1: reset, synchronous and active-high (1 = reset), sampled on the rising edge of `clk`.
- `mode`  in  2: pattern select; 0 binary count, 1 Gray count, 2 bounce, 3 rotate.
- `rate`  in  PRESCALE_WIDTH: step period minus one, in `clk` cycles; 0 steps every cycle.
- `pause`  in  1: freeze input; present only with `LED_PATTERN_GEN_PAUSE_EN` (see Configuration).
- `LED`  out  LED_WIDTH: registered pattern output, 1 = lit.
- `step`  out  1: registered one-cycle pulse, high in the cycle in which `LED` shows a newly advanced pattern.

## Operation
- Internal state:
  - `pre`, PRESCALE_WIDTH bits.
  - `cnt`, LED_WIDTH bits: binary/Gray counter.
  - `ring`, LED_WIDTH bits: rotate pattern.
  - `pos`, clog2(LED_WIDTH) bits, and `dir` (0 = up): bounce position and direction.
  - `mode_q`, 2 bits: last accepted mode.
- Reset, `NOTRESET`=1 at an edge:
  - `pre`=0, `cnt`=0, `ring`=1, `pos`=0, `dir`=0, `mode_q`=0.
  - `LED`=0, `step`=0.
  - Reset takes priority over every other input, including mid-step.
- Per-edge priority when not in reset:
  1. Mode change (`mode` != `mode_q`): `mode_q`<=`mode`, `pre`<=0, pattern state reloaded to the reset values above, `step`<=0. No advance in this cycle.
  2. Otherwise, if `pre` >= `rate`: `pre`<=0, the pattern of `mode_q` advances, `step`<=1.
  3. Otherwise: `pre`<=`pre`+1, `step`<=0.
- The `>=` compare means lowering `rate` below the current `pre` steps on the next edge. `pre` never wraps.
- Advance rules. Only the active pattern's state changes; the others hold.
  - Mode 0: `cnt`<=`cnt`+1, modulo 2^LED_WIDTH; all-ones wraps to 0.
  - Mode 1: same `cnt` increment.
  - Mode 2: if `dir`=0 and `pos`=LED_WIDTH-1, then `dir`<=1 and `pos`<=`pos`-1. If `dir`=1 and `pos`=0, then `dir`<=0 and `pos`<=1. Otherwise `pos` moves one place in `dir`. End positions are therefore shown once per sweep.
  - Mode 3: `ring` rotates left by one; the MSB feeds bit 0.
- `LED` is registered every edge from the post-update state:
  - Mode 0: `cnt`.
  - Mode 1: `cnt ^ (cnt >> 1)`.
  - Mode 2: `1 << pos`.
  - Mode 3: `ring`.
- `rate` is used live every cycle. `mode` is compared every cycle. Neither input is synchronised inside the block.

## Timing
- `LED` and `step` are outputs of flops and have no combinational path from any input.
- Step period is `rate`+1 cycles when `rate` is constant. With `rate`=0, `step` is high every cycle and the pattern advances every edge.
- First step after reset release or after a mode change: `rate`+1 edges after that event. `LED` shows the initial pattern of the new mode one edge after the change.
- Reset-release example, `mode`=3, `rate`=2:
  - Edge 1: mode change accepted, `LED`=0x01.
  - Edge 4: first step, `LED`=0x02.
- `step` and a new `LED` value appear on the same edge.

## Configuration
- `LED_PATTERN_GEN_PAUSE_EN` defined:
  - The `pause` port exists.
  - While `pause`=1 and there is no reset or mode change, `pre` and all pattern state hold, `step`=0, and `LED` holds.
  - A mode change during `pause` is still accepted and reloads state.
  - After `pause` deasserts, counting resumes from the held `pre`.
- `LED_PATTERN_GEN_PAUSE_EN` undefined: the port is absent and the block behaves as if `pause`=0.

## Test plan
- Reset, `mode`=0, `rate`=0, LED_WIDTH=8: `LED` reads 0,1,2,…,0xFF,0x00 on consecutive edges; `step` high every cycle after release.
- `mode`=1, `rate`=3: a `step` pulse every 4 cycles; `LED` sequence 0x00,0x01,0x03,0x02,0x06,0x07.
- `mode`=2, `rate`=0, LED_WIDTH=4: `LED` sequence 1,2,4,8,4,2,1,2.
- `mode`=3, `rate`=1:
  - `LED` 0x01,0x02,…,0x80,0x01, changing every 2 cycles.
  - Switch `mode` to 2 mid-sequence: next edge `LED`=0x01 with `step`=0.
  - First `step` comes 2 edges later, showing `LED`=0x02.
- `rate`=1000 with `pre` near 500, then `rate` set to 10: `step` asserts on the next edge and `pre` returns to 0. Assert `NOTRESET` on a step edge: `LED`=0 and `step`=0 after that edge.
- With `LED_PATTERN_GEN_PAUSE_EN`, `mode`=0, `rate`=0:
  - Hold `pause`=1 for 5 cycles: `LED` is frozen and `step`=0 throughout.
  - On release, counting continues from the frozen value +1.
